// File: rtl/pipe_skid_buf.sv
// Two-entry elastic pipeline register with valid/ready on both sides and a synchronous flush.
// o_ready, o_valid and o_data all come straight from flops.
module pipe_skid_buf #(
  parameter int P_WIDTH = 32
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_flush,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [P_WIDTH-1:0] i_data,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [P_WIDTH-1:0] o_data,
  output logic [1:0]         o_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [P_WIDTH-1:0]   out_q, out_d;
  logic [P_WIDTH-1:0]   skid_q, skid_d;
  logic                 ready_q;
  logic                 valid_q;
  logic                 in_fire;
  logic                 out_fire;

  assign in_fire  = i_valid & ready_q;
  assign out_fire = valid_q & i_ready;

  // Flush wins over everything; a word arriving in a flush cycle is simply not stored.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    if (i_flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d = BUSY;
            out_d   = i_data;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            out_d = i_data;
          end else if (in_fire) begin
            state_d = FULL;
            skid_d  = i_data;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_d = BUSY;
            out_d   = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Handshake flags are derived from the next state so they are registered yet never stale.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
      ready_q <= (state_d != FULL);
      valid_q <= (state_d != EMPTY);
    end
  end

  assign o_ready = ready_q;
  assign o_valid = valid_q;
  assign o_data  = out_q;
  assign o_count = state_q;

  a_count_legal: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    state_q != 2'd3);

  a_full_not_ready: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (state_q == FULL) |-> !ready_q);

  a_valid_tracks_state: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    valid_q == (state_q != EMPTY));

  // A stalled word must sit still until downstream takes it or a flush discards it.
  a_stall_stable: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (valid_q && !i_ready && !i_flush) |=> (valid_q && $stable(out_q)));

endmodule

// File: tb/tb_pipe_skid_buf.sv
// Randomised and directed bench for pipe_skid_buf; a word-queue model of the buffer
// doubles as the scoreboard that the negedge monitor checks and updates.
module tb_pipe_skid_buf;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_flush;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_data;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_data;
  logic [1:0]  o_count;

  int checks = 0;
  int errors = 0;

  logic [31:0] expQ[$];
  bit          started = 1'b0;
  bit          prevHold = 1'b0;
  logic [31:0] prevData = '0;
  bit          done = 1'b0;

  pipe_skid_buf #(.P_WIDTH(32)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_flush (i_flush),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_data  (i_data),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_data  (o_data),
    .o_count (o_count)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] d, input logic r, input logic f);
    @(posedge i_clk);
    #1;
    i_valid = v;
    i_data  = d;
    i_ready = r;
    i_flush = f;
  endtask

  // The model is just an ordered list of held words: ready means "fewer than two held,
  // and at least one clock edge seen since reset"; valid/count/data follow from the list.
  always @(negedge i_clk) begin
    if (!done) begin
      if (!i_rst_n) begin
        checkOutput("rst_valid", {31'd0, o_valid}, 32'd0);
        checkOutput("rst_ready", {31'd0, o_ready}, 32'd0);
        checkOutput("rst_count", {30'd0, o_count}, 32'd0);
        checkOutput("rst_data",  o_data, 32'd0);
        expQ.delete();
        started  = 1'b0;
        prevHold = 1'b0;
      end else begin
        bit expReady;
        bit inF;
        bit outF;
        expReady = started && (expQ.size() < 2);
        checkOutput("ready", {31'd0, o_ready}, {31'd0, expReady});
        checkOutput("valid", {31'd0, o_valid}, {31'd0, expQ.size() > 0});
        checkOutput("count", {30'd0, o_count}, 32'(expQ.size()));
        if (expQ.size() > 0)
          checkOutput("data", o_data, expQ[0]);
        if (prevHold) begin
          checkOutput("stall_valid", {31'd0, o_valid}, 32'd1);
          checkOutput("stall_data", o_data, prevData);
        end
        inF  = i_valid && expReady;
        outF = i_ready && (expQ.size() > 0);
        prevHold = (expQ.size() > 0) && !i_ready && !i_flush;
        prevData = o_data;
        if (i_flush) begin
          expQ.delete();
        end else begin
          if (outF) void'(expQ.pop_front());
          if (inF) expQ.push_back(i_data);
        end
        started = 1'b1;
      end
    end
  end

  initial begin
    i_rst_n = 1'b0;
    i_flush = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b0;
    i_data  = '0;
    repeat (3) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;

    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    // streaming
    applyStimulus(1'b1, 32'h11, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h22, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h33, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h44, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    // stall then drain
    applyStimulus(1'b1, 32'hA0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hB0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hEE, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    // simultaneous in/out while one word is held
    applyStimulus(1'b1, 32'h5, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h6, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    // flush from FULL with a word offered
    applyStimulus(1'b1, 32'hC1, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hC2, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hC3, 1'b1, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'hD1, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

    for (int i = 0; i < 10000; i++) begin
      applyStimulus(($urandom_range(0, 9) < 6), $urandom(),
                    ($urandom_range(0, 9) < 6), ($urandom_range(0, 49) == 0));
      if (i == 5000) begin
        // asynchronous reset in the middle of traffic
        #2;
        i_rst_n = 1'b0;
        #1;
        checkOutput("async_rst_valid", {31'd0, o_valid}, 32'd0);
        checkOutput("async_rst_count", {30'd0, o_count}, 32'd0);
        checkOutput("async_rst_ready", {31'd0, o_ready}, 32'd0);
        repeat (2) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
      end
    end

    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    @(negedge i_clk);
    #1;
    done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
